// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        REQ_LD  = 2'd0,
        REQ_ST  = 2'd1,
        REQ_BAD = 2'd2
    } req_e;

    // Classify a request at accept time: misaligned, out-of-range or
    // simultaneous load+store requests are rejected.
    function automatic req_e classify_req(input logic ld, input logic st,
                                          input logic [WORD_W-1:0] mar,
                                          input int unsigned depth);
        if (ld && st)
            return REQ_BAD;
        else if (mar[1:0] != 2'b00)
            return REQ_BAD;
        else if ({2'b00, mar[WORD_W-1:2]} >= depth)
            return REQ_BAD;
        else if (ld)
            return REQ_LD;
        else
            return REQ_ST;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Handshake and data bus between the MA stage and the memory responder.
interface dmem_if;
    import dmem_pkg::*;

    logic              isld;
    logic              isSt;
    logic [WORD_W-1:0] mar;
    logic [WORD_W-1:0] mdr;
    logic              req_ready;
    logic [WORD_W-1:0] ldresult;
    logic              ld_valid;
    logic              st_done;
    logic              err;

    modport master (
        output isld, isSt, mar, mdr,
        input  req_ready, ldresult, ld_valid, st_done, err
    );

    modport slave (
        input  isld, isSt, mar, mdr,
        output req_ready, ldresult, ld_valid, st_done, err
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, registered read. Not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Write or read the addressed word; read data is held until the next read.
    always_ff @(posedge clk) begin
        if (we_i)
            mem_q[addr_i] <= wdata_i;
        if (re_i)
            rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, models wait states, performs
// the word access and returns a registered one-cycle completion/error pulse.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    req_e              req_q, req_cur;
    logic [AW-1:0]     addr_q, addr_cur;
    logic [WORD_W-1:0] wdata_q, wdata_cur;
    logic              ready_q, ld_valid_q, st_done_q, err_q;
    logic [WORD_W-1:0] ldresult_q;
    logic [WORD_W-1:0] rdata;
    logic              accept, enter_resp, mem_we, mem_re;

    assign accept = (state_q == IDLE) && (bus.isld || bus.isSt);

    // With zero wait states RESP is entered on the accepting edge, so the
    // memory port must see the live request rather than the captured copy.
    assign req_cur   = (state_q == IDLE) ? classify_req(bus.isld, bus.isSt, bus.mar, DEPTH) : req_q;
    assign addr_cur  = (state_q == IDLE) ? bus.mar[AW+1:2] : addr_q;
    assign wdata_cur = (state_q == IDLE) ? bus.mdr : wdata_q;

    assign enter_resp = (state_d == RESP) && (state_q != RESP);
    assign mem_we     = enter_resp && !rst && (req_cur == REQ_ST);
    assign mem_re     = enter_resp && !rst && (req_cur == REQ_LD);

    // Next-state and wait-counter logic; the counter only loads on accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0)
                    state_d = RESP;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state and registered outputs; reset drops any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            ready_q    <= 1'b1;
            ld_valid_q <= 1'b0;
            st_done_q  <= 1'b0;
            err_q      <= 1'b0;
            ldresult_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= (state_d == IDLE);
            ld_valid_q <= (state_q == RESP) && (req_q == REQ_LD);
            st_done_q  <= (state_q == RESP) && (req_q == REQ_ST);
            err_q      <= (state_q == RESP) && (req_q == REQ_BAD);
            if ((state_q == RESP) && (req_q == REQ_LD))
                ldresult_q <= rdata;
        end
    end

    // Capture the request on accept; only meaningful while busy.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_q   <= req_cur;
            addr_q  <= addr_cur;
            wdata_q <= wdata_cur;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (addr_cur),
        .wdata_i (wdata_cur),
        .rdata_o (rdata)
    );

    assign bus.req_ready = ready_q;
    assign bus.ldresult  = ldresult_q;
    assign bus.ld_valid  = ld_valid_q;
    assign bus.st_done   = st_done_q;
    assign bus.err       = err_q;

endmodule
